// File: rtl/mem_port_master_if.sv
// Request/response and memory data-port bundle for mem_port_master.
// A request transfers on a rising edge where req_valid & req_ready; rsp_valid is a one-cycle pulse with no backpressure.
interface mem_port_master_if #(
  parameter int DATA_W = 20,
  parameter int ADDR_W = 5
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_wr_en;
  logic [DATA_W-1:0] q_mem;
  logic              sb_empty;

  modport master (
    input  req_valid, req_we, req_addr, req_wdata, q_mem,
    output req_ready, rsp_valid, rsp_data, mem_addr, mem_data, mem_wr_en, sb_empty
  );

  modport slave (
    output req_valid, req_we, req_addr, req_wdata, q_mem,
    input  req_ready, rsp_valid, rsp_data, mem_addr, mem_data, mem_wr_en, sb_empty
  );
endinterface

// File: rtl/mem_port_master.sv
// Data-port initiator: FIFO store buffer drained one write per cycle, fixed-latency loads.
// Optional macro MEM_STORE_FWD_EN: loads bypass a non-empty buffer and take the newest matching store's data.
module mem_port_master #(
  parameter int DATA_W   = 20,
  parameter int ADDR_W   = 5,
  parameter int SB_DEPTH = 4
) (
  input  logic                 Clock,
  input  logic                 Resetn,
  mem_port_master_if.master    bus,
  output logic [1:0]           dbg_state
);
  localparam int PTR_W = $clog2(SB_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(SB_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] sb_addr [SB_DEPTH];
  logic [DATA_W-1:0] sb_data [SB_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr, nxt_rd;
  logic [CNT_W-1:0]  count, count_nxt;
  logic              not_full, load_ok, push, load_acc, pop, load_presented;
  logic [ADDR_W-1:0] next_addr;
  logic [DATA_W-1:0] next_data;

`ifdef MEM_STORE_FWD_EN
  logic              fwd_hit, fwd_hit_c;
  logic [DATA_W-1:0] fwd_data, fwd_data_c;
  logic [PTR_W-1:0]  fwd_idx;
`endif

  assign dbg_state = state;

  always_comb begin
    not_full = (count < FULL);
`ifdef MEM_STORE_FWD_EN
    load_ok = (state == IDLE) && not_full;
`else
    load_ok = (state == IDLE) && (count == '0);
`endif
    bus.req_ready  = bus.req_we ? not_full : load_ok;
    bus.sb_empty   = (count == '0);
    push           = bus.req_valid & bus.req_ready & bus.req_we;
    load_acc       = bus.req_valid & bus.req_ready & ~bus.req_we;
    load_presented = bus.req_valid & ~bus.req_we;
    pop            = (state == DRAIN);
    count_nxt      = count + CNT_W'(push) - CNT_W'(pop);
    nxt_rd         = rd_ptr + 1'b1;
    // With one entry left, the next head is the store arriving on this very edge.
    if ((count == CNT_W'(1)) && push) begin
      next_addr = bus.req_addr;
      next_data = bus.req_wdata;
    end else begin
      next_addr = sb_addr[nxt_rd];
      next_data = sb_data[nxt_rd];
    end
  end

`ifdef MEM_STORE_FWD_EN
  // Walk oldest to newest so the last hit is the youngest store to that address.
  always_comb begin
    fwd_hit_c  = 1'b0;
    fwd_data_c = '0;
    fwd_idx    = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      fwd_idx = rd_ptr + PTR_W'(i);
      if ((CNT_W'(i) < count) && (sb_addr[fwd_idx] == bus.req_addr)) begin
        fwd_hit_c  = 1'b1;
        fwd_data_c = sb_data[fwd_idx];
      end
    end
  end
`endif

  always_ff @(posedge Clock) begin
    if (push) begin
      sb_addr[wr_ptr] <= bus.req_addr;
      sb_data[wr_ptr] <= bus.req_wdata;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state         <= IDLE;
      count         <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      bus.mem_addr  <= '0;
      bus.mem_data  <= '0;
      bus.mem_wr_en <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= '0;
`ifdef MEM_STORE_FWD_EN
      fwd_hit       <= 1'b0;
      fwd_data      <= '0;
`endif
    end else begin
      bus.rsp_valid <= 1'b0;
      count         <= count_nxt;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= nxt_rd;
      case (state)
        IDLE: begin
          if (load_acc) begin
            bus.mem_addr  <= bus.req_addr;
            bus.mem_wr_en <= 1'b0;
`ifdef MEM_STORE_FWD_EN
            fwd_hit       <= fwd_hit_c;
            fwd_data      <= fwd_data_c;
`endif
            state         <= LOAD;
          end else if (count != '0) begin
            bus.mem_addr  <= sb_addr[rd_ptr];
            bus.mem_data  <= sb_data[rd_ptr];
            bus.mem_wr_en <= 1'b1;
            state         <= DRAIN;
          end else begin
            bus.mem_wr_en <= 1'b0;
          end
        end
        LOAD: begin
`ifdef MEM_STORE_FWD_EN
          bus.rsp_data  <= fwd_hit ? fwd_data : bus.q_mem;
`else
          bus.rsp_data  <= bus.q_mem;
`endif
          bus.rsp_valid <= 1'b1;
          bus.mem_wr_en <= 1'b0;
          state         <= IDLE;
        end
        DRAIN: begin
          // A waiting load gets the port back between writes.
          if ((count_nxt != '0) && !load_presented) begin
            bus.mem_addr  <= next_addr;
            bus.mem_data  <= next_data;
            bus.mem_wr_en <= 1'b1;
          end else begin
            bus.mem_wr_en <= 1'b0;
            state         <= IDLE;
          end
        end
        default: begin
          bus.mem_wr_en <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end
endmodule
